// File: rtl/decode_pkg.sv
// decode_pkg: shared decode control encodings, the decode_ctrl_t record and ALU helper.
//   Exports PC_*/IMM_*/MEM_*/ALU_*/A_*/B_*/RD_* constants, RV32 opcodes,
//   decode_ctrl_t, DECODE_CTRL_W and alu_base().
package decode_pkg;

    localparam logic [2:0] PC_PLUS4  = 3'd0;
    localparam logic [2:0] PC_JAL    = 3'd1;
    localparam logic [2:0] PC_JALR   = 3'd2;
    localparam logic [2:0] PC_BRANCH = 3'd3;
    localparam logic [2:0] PC_TRAP   = 3'd4;
    localparam logic [2:0] PC_MRET   = 3'd5;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_Z    = 3'd6;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    // M-extension ops are laid out as {2'b10, func3} so decode can build them directly.
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic       B_RS2  = 1'b0;
    localparam logic       B_IMM  = 1'b1;

    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_PC4 = 2'd2;
    localparam logic [1:0] RD_CSR = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef struct packed {
        logic [2:0]  pc_ctrl;
        logic [2:0]  imm_type;
        logic [3:0]  mem_ctrl;
        logic [4:0]  alu_ctrl;
        logic [1:0]  alu_a_sel;
        logic        alu_b_sel;
        logic        reg_w_en;
        logic [1:0]  reg_rd_sel;
        logic        csr_we;
        logic [2:0]  func3;
        logic [11:0] csr_addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic        target_en;
        logic        target_jump;
        logic        ebreak;
        logic        ecall;
        logic        mret;
    } decode_ctrl_t;

    localparam int DECODE_CTRL_W = $bits(decode_ctrl_t);

    // Base integer ALU op shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I(+M, +Zicsr/MRET) instruction decoder.
//   inst    in  32              raw instruction
//   ctrl    out decode_ctrl_t   control record
//   illegal out 1               encoding is illegal under the enabled extensions
module decode_comb
    import decode_pkg::*;
#(
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0]  inst,
    output decode_ctrl_t ctrl,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [6:0] func7;
    logic [2:0] f3;

    assign opcode = inst[6:0];
    assign func7  = inst[31:25];
    assign f3     = inst[14:12];

    always_comb begin
        ctrl          = '0;
        illegal       = 1'b0;
        ctrl.func3    = f3;
        ctrl.csr_addr = inst[31:20];
        ctrl.rs1      = inst[19:15];
        ctrl.rs2      = inst[24:20];
        ctrl.rd       = inst[11:7];
        case (opcode)
            OPC_LUI: begin
                ctrl.imm_type  = IMM_U;
                ctrl.alu_ctrl  = ALU_PASSB;
                ctrl.alu_a_sel = A_ZERO;
                ctrl.alu_b_sel = B_IMM;
                ctrl.reg_w_en  = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.imm_type  = IMM_U;
                ctrl.alu_a_sel = A_PC;
                ctrl.alu_b_sel = B_IMM;
                ctrl.reg_w_en  = 1'b1;
            end
            OPC_JAL: begin
                ctrl.pc_ctrl     = PC_JAL;
                ctrl.imm_type    = IMM_J;
                ctrl.alu_a_sel   = A_PC;
                ctrl.alu_b_sel   = B_IMM;
                ctrl.reg_w_en    = 1'b1;
                ctrl.reg_rd_sel  = RD_PC4;
                ctrl.target_en   = 1'b1;
                ctrl.target_jump = 1'b1;
            end
            OPC_JALR: begin
                illegal          = f3 != 3'd0;
                ctrl.pc_ctrl     = PC_JALR;
                ctrl.imm_type    = IMM_I;
                ctrl.alu_b_sel   = B_IMM;
                ctrl.reg_w_en    = 1'b1;
                ctrl.reg_rd_sel  = RD_PC4;
                ctrl.rs1_used    = 1'b1;
                ctrl.target_en   = 1'b1;
                ctrl.target_jump = 1'b1;
            end
            OPC_BRANCH: begin
                illegal        = f3 == 3'd2 || f3 == 3'd3;
                ctrl.pc_ctrl   = PC_BRANCH;
                ctrl.imm_type  = IMM_B;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.rs1_used  = 1'b1;
                ctrl.rs2_used  = 1'b1;
                ctrl.target_en = 1'b1;
            end
            OPC_LOAD: begin
                illegal         = f3 == 3'd3 || f3 > 3'd5;
                ctrl.mem_ctrl   = f3 == 3'd0 ? MEM_LB :
                                  f3 == 3'd1 ? MEM_LH :
                                  f3 == 3'd2 ? MEM_LW :
                                  f3 == 3'd4 ? MEM_LBU : MEM_LHU;
                ctrl.imm_type   = IMM_I;
                ctrl.alu_b_sel  = B_IMM;
                ctrl.reg_w_en   = 1'b1;
                ctrl.reg_rd_sel = RD_MEM;
                ctrl.rs1_used   = 1'b1;
            end
            OPC_STORE: begin
                illegal        = f3 > 3'd2;
                ctrl.mem_ctrl  = f3 == 3'd0 ? MEM_SB : f3 == 3'd1 ? MEM_SH : MEM_SW;
                ctrl.imm_type  = IMM_S;
                ctrl.alu_b_sel = B_IMM;
                ctrl.rs1_used  = 1'b1;
                ctrl.rs2_used  = 1'b1;
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse func7 as an opcode extension; everything else is a plain immediate.
                illegal        = (f3 == 3'd1 && func7 != 7'h00) ||
                                 (f3 == 3'd5 && func7 != 7'h00 && func7 != 7'h20);
                ctrl.alu_ctrl  = alu_base(f3, f3 == 3'd5 && func7[5]);
                ctrl.imm_type  = IMM_I;
                ctrl.alu_b_sel = B_IMM;
                ctrl.reg_w_en  = 1'b1;
                ctrl.rs1_used  = 1'b1;
            end
            OPC_OP: begin
                if (func7 == 7'h01) begin
                    illegal       = !EN_M;
                    ctrl.alu_ctrl = {2'b10, f3};
                end else begin
                    illegal       = !(func7 == 7'h00 || (func7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                    ctrl.alu_ctrl = alu_base(f3, func7[5]);
                end
                ctrl.reg_w_en = 1'b1;
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
            end
            OPC_FENCE: begin
                illegal = f3 != 3'd0;
            end
            OPC_SYSTEM: begin
                if (f3 == 3'd0) begin
                    ctrl.ecall   = inst == INST_ECALL;
                    ctrl.ebreak  = inst == INST_EBREAK;
                    ctrl.mret    = EN_CSR && inst == INST_MRET;
                    ctrl.pc_ctrl = ctrl.mret ? PC_MRET : PC_TRAP;
                    illegal      = !(ctrl.ecall || ctrl.ebreak || ctrl.mret);
                end else begin
                    // CSRRS/CSRRC (and immediate forms) with a zero source are read-only accesses.
                    illegal         = !EN_CSR || f3 == 3'd4;
                    ctrl.imm_type   = f3[2] ? IMM_Z : IMM_NONE;
                    ctrl.rs1_used   = !f3[2];
                    ctrl.reg_w_en   = 1'b1;
                    ctrl.reg_rd_sel = RD_CSR;
                    ctrl.csr_we     = f3[1:0] == 2'd1 || inst[19:15] != 5'd0;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl.pc_ctrl     = PC_TRAP;
            ctrl.reg_w_en    = 1'b0;
            ctrl.csr_we      = 1'b0;
            ctrl.mem_ctrl    = MEM_NONE;
            ctrl.target_en   = 1'b0;
            ctrl.target_jump = 1'b0;
            ctrl.ecall       = 1'b0;
            ctrl.ebreak      = 1'b0;
            ctrl.mret        = 1'b0;
        end
        if (ctrl.rd == 5'd0) ctrl.reg_w_en = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode pipeline stage with a DEPTH-entry output FIFO and valid/ready handshakes.
//   clk, rst                      clock, synchronous active-high reset
//   flush_i                       drop buffered entries and any same-cycle input
//   in_valid_i/in_ready_o         upstream handshake for inst_i/pc_i
//   out_valid_o/out_ready_i       downstream handshake for the head entry
//   ctrl_o, pc_o, illegal_o       head entry payload (all zero while empty)
module decode_stage
    import decode_pkg::*;
#(
    parameter bit EN_M   = 1'b1,
    parameter bit EN_CSR = 1'b1,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DECODE_CTRL_W-1:0] ctrl_o,
    output logic [31:0]              pc_o,
    output logic                     illegal_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    decode_ctrl_t dec_ctrl;
    logic         dec_illegal;

    decode_comb #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_decode_comb (
        .inst    (inst_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    decode_ctrl_t  ctrl_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          ill_mem  [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic          push;
    logic          pop;

    // Ready comes only from the registered count, so a full buffer cannot accept even while popping.
    assign in_ready_o  = count < FULL;
    assign out_valid_o = count != '0;
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
            if (push) wptr <= wptr == LAST ? '0 : wptr + PW'(1);
            if (pop) rptr <= rptr == LAST ? '0 : rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wptr] <= dec_ctrl;
            pc_mem[wptr]   <= pc_i;
            ill_mem[wptr]  <= dec_illegal;
        end
    end

    // Payload storage is never reset, so outputs are gated to zero while the buffer is empty.
    assign ctrl_o    = out_valid_o ? ctrl_mem[rptr] : '0;
    assign pc_o      = out_valid_o ? pc_mem[rptr] : '0;
    assign illegal_o = out_valid_o && ill_mem[rptr];

endmodule
